// File: rtl/sha512_seq_pkg.sv
// Shared sizing and FSM encoding for the SHA-512 block sequencer.
// Holds no logic; latency and backpressure are not applicable.
package sha512_seq_pkg;
   localparam int WORD_W    = 32;
   localparam int NUM_WORDS = 32;
   localparam int IDX_W     = $clog2(NUM_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FULL   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } seq_state_e;
endpackage

// File: rtl/blk_word_counter.sv
// Wrapping word-index counter for the stream side; count updates one cycle after inc.
// No backpressure of its own: inc is the caller's transfer qualifier, clr wins over inc.
module blk_word_counter
   import sha512_seq_pkg::*;
#(
   parameter int CNT_W   = IDX_W,
   parameter int CNT_MAX = NUM_WORDS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             last
);
   localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(CNT_MAX - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign last  = (count_q == LAST_VAL);
   assign count = count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = last ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/sha512_block_sequencer.sv
// Buffers one 1024-bit block and streams it word by word; first word valid the cycle after start_i.
// Load side stalls (wr_ready_o=0) until the block drains; stream words hold while out_ready_i=0.
module sha512_block_sequencer #(
   parameter int  WORD_W    = sha512_seq_pkg::WORD_W,
   parameter int  NUM_WORDS = sha512_seq_pkg::NUM_WORDS,
   localparam int IDX_W     = $clog2(NUM_WORDS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              abort_i,
   input  logic              wr_valid_i,
   input  logic [WORD_W-1:0] wr_data_i,
   output logic              wr_ready_o,
   output logic              full_o,
   input  logic              start_i,
   output logic              out_valid_o,
   output logic [WORD_W-1:0] out_data_o,
   output logic [IDX_W-1:0]  out_idx_o,
   input  logic              out_ready_i,
   output logic              busy_o,
   output logic              done_o
);
   import sha512_seq_pkg::*;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   seq_state_e        state_q;
   seq_state_e        state_d;
   logic [IDX_W-1:0]  wr_ptr_q;
   logic [IDX_W-1:0]  wr_ptr_d;
   logic [WORD_W-1:0] buf_q [NUM_WORDS];
   logic [IDX_W-1:0]  rd_idx;
   logic              rd_last;
   logic              wr_fire;
   logic              rd_fire;

   // abort_i masks both the load write and the stream transfer in its cycle
   assign wr_fire = reset && !abort_i && (state_q == ST_IDLE) && wr_valid_i;
   assign rd_fire = !abort_i && (state_q == ST_STREAM) && out_ready_i;

   blk_word_counter #(
      .CNT_W   (IDX_W),
      .CNT_MAX (NUM_WORDS)
   ) u_rd_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (abort_i),
      .inc   (rd_fire),
      .count (rd_idx),
      .last  (rd_last)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      if (abort_i) begin
         state_d  = ST_IDLE;
         wr_ptr_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (wr_valid_i) begin
                  if (wr_ptr_q == LAST_IDX) begin
                     wr_ptr_d = '0;
                     state_d  = ST_FULL;
                  end else begin
                     wr_ptr_d = wr_ptr_q + 1'b1;
                  end
               end
            end
            ST_FULL: begin
               if (start_i) state_d = ST_STREAM;
            end
            ST_STREAM: begin
               if (out_ready_i && rd_last) state_d = ST_DONE;
            end
            ST_DONE: begin
               state_d  = ST_IDLE;
               wr_ptr_d = '0;
            end
            default: begin
               state_d  = ST_IDLE;
               wr_ptr_d = '0;
            end
         endcase
      end
   end

   always_comb begin
      wr_ready_o  = (state_q == ST_IDLE);
      full_o      = (state_q == ST_FULL);
      out_valid_o = (state_q == ST_STREAM);
      busy_o      = (state_q == ST_STREAM);
      done_o      = (state_q == ST_DONE);
      out_idx_o   = rd_idx;
      out_data_o  = buf_q[rd_idx];
   end

   // Storage is never cleared: a completed or aborted block leaves stale words behind
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         buf_q[wr_ptr_q] <= wr_data_i;
      end
   end
endmodule

// File: doc/sha512_block_sequencer.md
SHA512_BLOCK_SEQUENCER -- requirements
Module: sha512_block_sequencer

Interface
REQ-001 Parameter WORD_W, 32, width of one message word.
REQ-002 Parameter NUM_WORDS, 32, words per 1024-bit SHA-512 block; IDX_W = clog2(NUM_WORDS) = 5.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 abort_i  in  1  discard current block and return to IDLE.
REQ-006 wr_valid_i  in  1  load-side word valid.
REQ-007 wr_data_i  in  WORD_W  load-side word.
REQ-008 wr_ready_o  out  1  sequencer accepts a load word.
REQ-009 full_o  out  1  all NUM_WORDS words buffered, awaiting start.
REQ-010 start_i  in  1  single-cycle request to stream the buffered block to the hash core.
REQ-011 out_valid_o  out  1  stream word valid.
REQ-012 out_data_o  out  WORD_W  stream word; equals buffer[out_idx_o].
REQ-013 out_idx_o  out  IDX_W  index of current stream word.
REQ-014 out_ready_i  in  1  hash core accepts stream word.
REQ-015 busy_o  out  1  high in STREAM.
REQ-016 done_o  out  1  one-cycle pulse after last word is transferred.

Function
REQ-017 FSM states: IDLE (loading), FULL, STREAM, DONE.
REQ-018 IDLE: wr_ready_o=1; on wr_valid_i, store wr_data_i at buffer[wr_ptr] and increment wr_ptr.
REQ-019 IDLE -> FULL on the write with wr_ptr = NUM_WORDS-1; wr_ptr wraps to 0.
REQ-020 FULL: full_o=1, wr_ready_o=0; writes ignored.
REQ-021 start_i is ignored in every state except FULL.
REQ-022 FULL with start_i at edge N -> STREAM; out_valid_o=1 with out_idx_o=0 from cycle N+1.
REQ-023 STREAM: word transfers when out_valid_o & out_ready_i; out_idx_o increments by 1 on each transfer.
REQ-024 While out_valid_o=1 and out_ready_i=0, out_data_o and out_idx_o hold stable.
REQ-025 Transfer at out_idx_o = NUM_WORDS-1 -> DONE; out_idx_o wraps to 0; out_valid_o=0 in DONE.
REQ-026 DONE lasts exactly one cycle with done_o=1, then goes to IDLE with wr_ptr=0.
REQ-027 Buffer contents are not cleared at completion; only the pointers reset.
REQ-028 abort_i=1 at any edge -> IDLE, wr_ptr=0, out_idx_o=0; done_o is not pulsed.
REQ-029 abort_i has priority over start_i, wr_valid_i and a stream transfer in the same cycle.
REQ-030 Throughput: one word per cycle when out_ready_i is held high; a full block streams in NUM_WORDS cycles.

Reset
REQ-031 reset=0 at a rising edge forces IDLE, wr_ptr=0 and out_idx_o=0.
REQ-032 After reset, outputs are: wr_ready_o=1, full_o=0, out_valid_o=0, busy_o=0, done_o=0, out_idx_o=0.
REQ-033 The buffer array is not reset; out_data_o is don't-care while out_valid_o=0.
REQ-034 Reset mid-STREAM behaves as abort: no done_o, no further out_valid_o.

Structure
REQ-035 Shared package sha512_seq_pkg holds WORD_W, NUM_WORDS, IDX_W and the FSM state encoding.
REQ-036 The read index counter is one sub-module, blk_word_counter, with ports clk, reset, clr, inc, count[IDX_W-1:0] and last.
REQ-037 The buffer is an inferred register array of NUM_WORDS x WORD_W.

Verification
REQ-038 Reset, load 32 words 0xDEAD0000..0xDEAD001F back-to-back -> full_o=1 after 32nd write; wr_ready_o=0.
REQ-039 start_i pulse with out_ready_i=1 -> 32 consecutive cycles with out_idx_o 0..31 and out_data_o 0xDEAD0000..0xDEAD001F; then done_o for 1 cycle; then wr_ready_o=1.
REQ-040 out_ready_i toggled 1/0 each cycle -> each word held stable while stalled; 64 cycles to done_o; no word skipped or duplicated.
REQ-041 start_i during IDLE after 10 writes -> no out_valid_o; 22 more writes then start_i -> normal stream.
REQ-042 abort_i at out_idx_o=7 -> IDLE next cycle; no done_o; wr_ptr=0 (next write lands at index 0).
REQ-043 reset=0 for one cycle mid-STREAM -> all outputs at reset values next cycle; a new block of 32 writes loads and streams correctly.
